// File: rtl/fight_pkg.sv
// Shared types and constants for the fighting-game match sequencer.
//   - state_e        : sequencer states
//   - ACT_W          : action width toward the core
//   - IDLE_ACTION_DFLT: action substituted when a player times out
//   - WINNER_*       : matchWinner encodings
//   - winner_of()    : score comparison for the final result
package fight_pkg;

   localparam int ACT_W = 3;
   localparam int TMR_W = 4;

   localparam logic [ACT_W-1:0] IDLE_ACTION_DFLT = 3'b000;

   localparam logic [1:0] WINNER_NONE = 2'b00;
   localparam logic [1:0] WINNER_P1   = 2'b01;
   localparam logic [1:0] WINNER_P2   = 2'b10;
   localparam logic [1:0] WINNER_TIE  = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      RESET_GAME,
      COLLECT,
      ISSUE,
      GAP,
      CHECK,
      ROUND_END,
      MATCH_END
   } state_e;

   function automatic logic [1:0] winner_of(input logic [1:0] s1, input logic [1:0] s2);
      if (s1 > s2)      return WINNER_P1;
      else if (s2 > s1) return WINNER_P2;
      else              return WINNER_TIE;
   endfunction

endpackage

// File: rtl/fight_match_ctrl_if.sv
// Bus between the match sequencer and its environment (players + core).
//   master : testbench / system side (drives requests, core win flags)
//   slave  : fight_match_ctrl side (drives readies, core actions, status)
interface fight_match_ctrl_if;
   import fight_pkg::*;

   logic             startMatch;
   logic             req1Valid;
   logic [ACT_W-1:0] req1Action;
   logic             req1Ready;
   logic             req2Valid;
   logic [ACT_W-1:0] req2Action;
   logic             req2Ready;
   logic             firstWin;
   logic             secondWin;
   logic [ACT_W-1:0] action1;
   logic [ACT_W-1:0] action2;
   logic             actionEnable;
   logic             gameResetN;
   logic [1:0]       score1;
   logic [1:0]       score2;
   logic [2:0]       roundNum;
   logic             matchOver;
   logic [1:0]       matchWinner;
   logic             busy;

   modport master (
      output startMatch, req1Valid, req1Action, req2Valid, req2Action, firstWin, secondWin,
      input  req1Ready, req2Ready, action1, action2, actionEnable, gameResetN,
             score1, score2, roundNum, matchOver, matchWinner, busy
   );

   modport slave (
      input  startMatch, req1Valid, req1Action, req2Valid, req2Action, firstWin, secondWin,
      output req1Ready, req2Ready, action1, action2, actionEnable, gameResetN,
             score1, score2, roundNum, matchOver, matchWinner, busy
   );

endinterface

// File: rtl/fight_action_slot.sv
// One player's action slot: valid/ready capture with a timeout default.
//   clear        : empty the slot (action value is kept for the issue phase)
//   collect_nxt  : sequencer will be collecting next cycle
//   load_default : timeout cycle; an empty slot takes DEFAULT_ACTION
//   valid/action_in -> ready/full/action
module fight_action_slot
   import fight_pkg::*;
#(
   parameter logic [ACT_W-1:0] DEFAULT_ACTION = IDLE_ACTION_DFLT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             collect_nxt,
   input  logic             load_default,
   input  logic             valid,
   input  logic [ACT_W-1:0] action_in,
   output logic             ready,
   output logic             full,
   output logic [ACT_W-1:0] action
);

   logic             full_q, full_d;
   logic             ready_q, ready_d;
   logic [ACT_W-1:0] action_q, action_d;
   logic             accept;

   always_comb begin
      accept   = valid & ready_q;
      full_d   = full_q;
      action_d = action_q;
      // a real acceptance on the timeout cycle beats the default
      if (clear) begin
         full_d = 1'b0;
      end else if (accept) begin
         full_d   = 1'b1;
         action_d = action_in;
      end else if (load_default && !full_q) begin
         full_d   = 1'b1;
         action_d = DEFAULT_ACTION;
      end
      // ready is a flop so it drops the cycle after the slot fills
      ready_d = collect_nxt & ~full_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q   <= 1'b0;
         ready_q  <= 1'b0;
         action_q <= DEFAULT_ACTION;
      end else begin
         full_q   <= full_d;
         ready_q  <= ready_d;
         action_q <= action_d;
      end
   end

   assign ready  = ready_q;
   assign full   = full_q;
   assign action = action_q;

endmodule

// File: rtl/fight_match_ctrl.sv
// Best-of-N match sequencer for the two-player fighting-game core.
//   clk, reset : clock, async active-high reset
//   bus.slave  : player request handshakes, core action/enable/reset,
//                core win flags, score/round/match status
//
// state      | meaning
// IDLE       | core held in reset, waiting for startMatch
// RESET_GAME | core reset low for RESET_CYCLES
// COLLECT    | gathering one action per player, timeout running
// ISSUE      | actions applied, actionEnable for ENABLE_CYCLES
// GAP        | one quiet cycle before sampling the result
// CHECK      | sample firstWin/secondWin, score the round
// ROUND_END  | decide next round or match end
// MATCH_END  | result shown until a new startMatch
//
// All core-facing outputs are flops fed from the current state, so they
// follow the state by one cycle.
module fight_match_ctrl
   import fight_pkg::*;
#(
   parameter int               WINS_NEEDED   = 2,
   parameter int               MAX_ROUNDS    = 5,
   parameter int               TURN_TIMEOUT  = 8,
   parameter int               ENABLE_CYCLES = 2,
   parameter int               RESET_CYCLES  = 2,
   parameter logic [ACT_W-1:0] IDLE_ACTION   = IDLE_ACTION_DFLT
) (
   input  logic              clk,
   input  logic              reset,
   fight_match_ctrl_if.slave bus
);

   localparam logic [1:0]       WINS_L   = 2'(WINS_NEEDED);
   localparam logic [2:0]       MAX_L    = 3'(MAX_ROUNDS);
   localparam logic [TMR_W-1:0] TO_LOAD  = TMR_W'(TURN_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] EN_LOAD  = TMR_W'(ENABLE_CYCLES - 1);
   localparam logic [TMR_W-1:0] RST_LOAD = TMR_W'(RESET_CYCLES - 1);

   state_e           state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [1:0]       score1_q, score1_d, score2_q, score2_d;
   logic [1:0]       winner_q, winner_d;
   logic [2:0]       round_q, round_d;
   logic [ACT_W-1:0] action1_q, action1_d, action2_q, action2_d;
   logic             enable_q, enable_d, grst_n_q, grst_n_d;
   logic             over_q, over_d, busy_q, busy_d;

   logic             timeout, slot_clear, collect_nxt;
   logic             full1, full2, ready1, ready2;
   logic [ACT_W-1:0] slot1_action, slot2_action;

   fight_action_slot #(.DEFAULT_ACTION(IDLE_ACTION)) u_slot1 (
      .clk          (clk),
      .rst          (reset),
      .clear        (slot_clear),
      .collect_nxt  (collect_nxt),
      .load_default (timeout),
      .valid        (bus.req1Valid),
      .action_in    (bus.req1Action),
      .ready        (ready1),
      .full         (full1),
      .action       (slot1_action)
   );

   fight_action_slot #(.DEFAULT_ACTION(IDLE_ACTION)) u_slot2 (
      .clk          (clk),
      .rst          (reset),
      .clear        (slot_clear),
      .collect_nxt  (collect_nxt),
      .load_default (timeout),
      .valid        (bus.req2Valid),
      .action_in    (bus.req2Action),
      .ready        (ready2),
      .full         (full2),
      .action       (slot2_action)
   );

   always_comb begin
      state_d  = state_q;
      tmr_d    = tmr_q;
      score1_d = score1_q;
      score2_d = score2_q;
      round_d  = round_q;
      winner_d = winner_q;
      timeout  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.startMatch) begin
               state_d  = RESET_GAME;
               tmr_d    = RST_LOAD;
               score1_d = 2'd0;
               score2_d = 2'd0;
               round_d  = 3'd0;
               winner_d = WINNER_NONE;
            end
         end
         RESET_GAME: begin
            if (tmr_q == '0) begin
               state_d = COLLECT;
               tmr_d   = TO_LOAD;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         COLLECT: begin
            timeout = (tmr_q == '0);
            if ((full1 && full2) || timeout) begin
               state_d = ISSUE;
               tmr_d   = EN_LOAD;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         ISSUE: begin
            if (tmr_q == '0) state_d = GAP;
            else             tmr_d   = tmr_q - 1'b1;
         end
         GAP: begin
            state_d = CHECK;
         end
         CHECK: begin
            if (!bus.firstWin && !bus.secondWin) begin
               state_d = COLLECT;
               tmr_d   = TO_LOAD;
            end else begin
               if (bus.firstWin && !bus.secondWin && score1_q != 2'd3) score1_d = score1_q + 2'd1;
               if (bus.secondWin && !bus.firstWin && score2_q != 2'd3) score2_d = score2_q + 2'd1;
               if (round_q != 3'd7) round_d = round_q + 3'd1;
               state_d = ROUND_END;
            end
         end
         ROUND_END: begin
            if (score1_q == WINS_L || score2_q == WINS_L || round_q == MAX_L) begin
               state_d = MATCH_END;
            end else begin
               state_d = RESET_GAME;
               tmr_d   = RST_LOAD;
            end
         end
         MATCH_END: begin
            winner_d = winner_of(score1_q, score2_q);
            if (bus.startMatch) begin
               state_d  = RESET_GAME;
               tmr_d    = RST_LOAD;
               score1_d = 2'd0;
               score2_d = 2'd0;
               round_d  = 3'd0;
               winner_d = WINNER_NONE;
            end
         end
         default: state_d = IDLE;
      endcase

      // slots only fill in COLLECT; clearing just the full flag elsewhere
      // keeps the captured actions available to ISSUE
      slot_clear  = (state_q != COLLECT);
      collect_nxt = (state_d == COLLECT);

      enable_d  = (state_q == ISSUE);
      grst_n_d  = !(state_q == IDLE || state_q == RESET_GAME);
      over_d    = (state_q == MATCH_END);
      busy_d    = (state_q != IDLE);
      action1_d = (state_q == ISSUE) ? slot1_action : action1_q;
      action2_d = (state_q == ISSUE) ? slot2_action : action2_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         tmr_q     <= '0;
         score1_q  <= 2'd0;
         score2_q  <= 2'd0;
         round_q   <= 3'd0;
         winner_q  <= WINNER_NONE;
         action1_q <= IDLE_ACTION;
         action2_q <= IDLE_ACTION;
         enable_q  <= 1'b0;
         grst_n_q  <= 1'b0;
         over_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         score1_q  <= score1_d;
         score2_q  <= score2_d;
         round_q   <= round_d;
         winner_q  <= winner_d;
         action1_q <= action1_d;
         action2_q <= action2_d;
         enable_q  <= enable_d;
         grst_n_q  <= grst_n_d;
         over_q    <= over_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.req1Ready    = ready1;
   assign bus.req2Ready    = ready2;
   assign bus.action1      = action1_q;
   assign bus.action2      = action2_q;
   assign bus.actionEnable = enable_q;
   assign bus.gameResetN   = grst_n_q;
   assign bus.score1       = score1_q;
   assign bus.score2       = score2_q;
   assign bus.roundNum     = round_q;
   assign bus.matchOver    = over_q;
   assign bus.matchWinner  = winner_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_fight_match_ctrl.sv
// Self-checking bench for fight_match_ctrl: a directed table-driven match,
// randomized matches against a turn-level reference model, and a reset
// applied while actions are being issued.
module tb_fight_match_ctrl;
   import fight_pkg::*;

   localparam int T_TIMEOUT = 8;
   localparam int T_WINS    = 2;
   localparam int T_MAXRND  = 5;

   typedef struct {
      logic [2:0] a1;
      int         off1;   // window cycle when P1 starts offering, 0 = never
      logic [2:0] a2;
      int         off2;
      bit         fw;
      bit         sw;
      bit         poke;   // pulse startMatch mid-match (must be ignored)
      logic [2:0] e1;
      logic [2:0] e2;
      int         es1;
      int         es2;
      int         ernd;
   } turn_t;

   logic clk = 1'b0;
   logic reset;

   fight_match_ctrl_if bus();

   fight_match_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // lengths of core-reset pulses issued while busy
   int run_len = 0;
   int runs[$];
   always @(negedge clk) begin
      if (reset) run_len = 0;
      else if (bus.busy && !bus.gameResetN) run_len++;
      else if (bus.gameResetN && run_len > 0) begin
         runs.push_back(run_len);
         run_len = 0;
      end
   end

   // reference model: match state at turn granularity
   int m_s1, m_s2, m_rnd;

   function automatic logic [2:0] exp_act(input logic [2:0] a, input int off);
      return (off >= 1 && off <= T_TIMEOUT) ? a : IDLE_ACTION_DFLT;
   endfunction

   function automatic turn_t mk(input logic [2:0] a1, input int off1, input logic [2:0] a2,
                                input int off2, input bit fw, input bit sw, input bit poke,
                                input logic [2:0] e1, input logic [2:0] e2,
                                input int es1, input int es2, input int ernd);
      turn_t t;
      t.a1 = a1; t.off1 = off1; t.a2 = a2; t.off2 = off2;
      t.fw = fw; t.sw = sw; t.poke = poke;
      t.e1 = e1; t.e2 = e2; t.es1 = es1; t.es2 = es2; t.ernd = ernd;
      return t;
   endfunction

   task automatic start_match();
      runs.delete();
      bus.startMatch = 1'b1;
      @(negedge clk);
      bus.startMatch = 1'b0;
   endtask

   // Runs one turn; starts and ends on a falling edge.
   task automatic run_turn(input turn_t t, input string tag);
      int c = 0;
      int en_len = 0;
      bit acc1 = 0, acc2 = 0, got = 0, bad_ready = 0;
      for (int cyc = 0; cyc < 80 && !got; cyc++) begin
         bus.startMatch = t.poke && (cyc == 0);
         if (bus.actionEnable) begin
            got = 1;
         end else begin
            if (bus.req1Ready || bus.req2Ready) c++;
            if ((acc1 && bus.req1Ready) || (acc2 && bus.req2Ready)) bad_ready = 1;
            bus.req1Action = t.a1;
            bus.req2Action = t.a2;
            bus.req1Valid  = !acc1 && t.off1 > 0 && c > 0 && c >= t.off1;
            bus.req2Valid  = !acc2 && t.off2 > 0 && c > 0 && c >= t.off2;
            if (bus.req1Valid && bus.req1Ready) acc1 = 1;
            if (bus.req2Valid && bus.req2Ready) acc2 = 1;
            @(negedge clk);
         end
      end
      bus.startMatch = 1'b0;
      bus.req1Valid  = 1'b0;
      bus.req2Valid  = 1'b0;
      chk({tag, " enable_seen"}, 32'(got), 32'd1);
      chk({tag, " action1"}, 32'(bus.action1), 32'(t.e1));
      chk({tag, " action2"}, 32'(bus.action2), 32'(t.e2));
      bus.firstWin  = t.fw;
      bus.secondWin = t.sw;
      for (int cyc = 0; cyc < 10 && bus.actionEnable; cyc++) begin
         en_len++;
         @(negedge clk);
      end
      chk({tag, " enable_len"}, 32'(en_len), 32'd2);
      chk({tag, " action_hold"}, {29'd0, bus.action1}, 32'(t.e1));
      chk({tag, " ready_drop"}, 32'(bad_ready), 32'd0);
      @(negedge clk);
      chk({tag, " score1"}, 32'(bus.score1), 32'(t.es1));
      chk({tag, " score2"}, 32'(bus.score2), 32'(t.es2));
      chk({tag, " round"}, 32'(bus.roundNum), 32'(t.ernd));
   endtask

   task automatic check_match_end(input string tag, input logic [1:0] want);
      for (int i = 0; i < 10 && !bus.matchOver; i++) @(negedge clk);
      chk({tag, " over"}, 32'(bus.matchOver), 32'd1);
      chk({tag, " winner"}, 32'(bus.matchWinner), 32'(want));
      chk({tag, " core_run"}, 32'(bus.gameResetN), 32'd1);
      repeat (4) @(negedge clk);
      chk({tag, " holds"}, {30'd0, bus.matchOver, bus.busy}, 32'd3);
   endtask

   task automatic check_runs(input string tag, input int want_n);
      int bad = 0;
      foreach (runs[i]) if (runs[i] != 2) bad++;
      chk({tag, " rst_pulses"}, 32'(runs.size()), 32'(want_n));
      chk({tag, " rst_pulse_len"}, 32'(bad), 32'd0);
      runs.delete();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      turn_t tbl[6];
      turn_t t;
      bit    ended;
      int    resets_exp;
      int    r;
      logic [1:0] want_w;

      tbl[0] = mk(3'b100, 1, 3'b110, 1, 0, 0, 0, 3'b100, 3'b110, 0, 0, 0);
      tbl[1] = mk(3'b111, 0, 3'b010, 3, 0, 0, 0, 3'b000, 3'b010, 0, 0, 0);
      tbl[2] = mk(3'b101, 8, 3'b001, 2, 1, 0, 0, 3'b101, 3'b001, 1, 0, 1);
      tbl[3] = mk(3'b111, 2, 3'b011, 5, 1, 1, 1, 3'b111, 3'b011, 1, 0, 2);
      tbl[4] = mk(3'b010, 9, 3'b111, 1, 0, 1, 1, 3'b000, 3'b111, 1, 1, 3);
      tbl[5] = mk(3'b001, 4, 3'b100, 4, 1, 0, 0, 3'b001, 3'b100, 2, 1, 4);

      reset          = 1'b1;
      bus.startMatch = 1'b0;
      bus.req1Valid  = 1'b0;
      bus.req1Action = 3'b000;
      bus.req2Valid  = 1'b0;
      bus.req2Action = 3'b000;
      bus.firstWin   = 1'b0;
      bus.secondWin  = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst gameResetN", 32'(bus.gameResetN), 32'd0);
      chk("rst actionEnable", 32'(bus.actionEnable), 32'd0);
      chk("rst busy", 32'(bus.busy), 32'd0);
      chk("rst readies", {30'd0, bus.req1Ready, bus.req2Ready}, 32'd0);
      chk("rst actions", {26'd0, bus.action1, bus.action2}, 32'd0);
      chk("rst status", {23'd0, bus.score1, bus.score2, bus.roundNum, bus.matchOver, bus.matchWinner}, 32'd0);

      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle busy", 32'(bus.busy), 32'd0);
      chk("idle gameResetN", 32'(bus.gameResetN), 32'd0);

      // directed match from the table
      start_match();
      for (int i = 0; i < 6; i++) run_turn(tbl[i], $sformatf("dir%0d", i));
      check_match_end("dir", WINNER_P1);
      check_runs("dir", 4);

      // randomized matches against the model
      for (int m = 0; m < 4; m++) begin
         m_s1 = 0; m_s2 = 0; m_rnd = 0;
         resets_exp = 1;
         ended = 0;
         start_match();
         for (int k = 0; k < 60 && !ended; k++) begin
            t.a1   = 3'($urandom_range(0, 7));
            t.a2   = 3'($urandom_range(0, 7));
            t.off1 = $urandom_range(0, 10);
            t.off2 = $urandom_range(0, 10);
            r      = $urandom_range(0, 9);
            t.fw   = (r >= 4 && r < 7) || r == 9;
            t.sw   = (r >= 7);
            t.poke = ($urandom_range(0, 7) == 0);
            t.e1   = exp_act(t.a1, t.off1);
            t.e2   = exp_act(t.a2, t.off2);
            if (t.fw && !t.sw) m_s1 = (m_s1 < 3) ? m_s1 + 1 : 3;
            if (t.sw && !t.fw) m_s2 = (m_s2 < 3) ? m_s2 + 1 : 3;
            if (t.fw || t.sw) m_rnd = (m_rnd < 7) ? m_rnd + 1 : 7;
            t.es1  = m_s1;
            t.es2  = m_s2;
            t.ernd = m_rnd;
            run_turn(t, $sformatf("rnd%0d_%0d", m, k));
            if (t.fw || t.sw) begin
               if (m_s1 == T_WINS || m_s2 == T_WINS || m_rnd == T_MAXRND) ended = 1;
               else resets_exp++;
            end
         end
         chk($sformatf("rnd%0d ended", m), 32'(ended), 32'd1);
         want_w = (m_s1 > m_s2) ? 2'b01 : (m_s2 > m_s1) ? 2'b10 : 2'b11;
         check_match_end($sformatf("rnd%0d", m), want_w);
         check_runs($sformatf("rnd%0d", m), resets_exp);
      end

      // restart from MATCH_END clears the result
      start_match();
      @(negedge clk);
      chk("restart scores", {27'd0, bus.score1, bus.score2, bus.roundNum}, 32'd0);
      @(negedge clk);
      chk("restart over", {30'd0, bus.matchOver, bus.matchWinner != 2'b00}, 32'd0);

      // reset while actions are being issued
      bus.req1Action = 3'b011;
      bus.req2Action = 3'b101;
      bus.req1Valid  = 1'b1;
      bus.req2Valid  = 1'b1;
      for (int i = 0; i < 40 && !bus.actionEnable; i++) @(negedge clk);
      chk("issue enable", 32'(bus.actionEnable), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("async enable_drop", 32'(bus.actionEnable), 32'd0);
      chk("async gameResetN", 32'(bus.gameResetN), 32'd0);
      chk("async busy", 32'(bus.busy), 32'd0);
      chk("async actions", {26'd0, bus.action1, bus.action2}, 32'd0);
      bus.req1Valid = 1'b0;
      bus.req2Valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
